// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the fetch stage and the Control/decode blocks
package mips_pkg;
    localparam int          PC_W_DEFAULT = 8;
    localparam int          PC_STEP      = 4;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [15:0] STALL_MAX    = 16'hFFFF;
    localparam logic [5:0]  OP_BEQ       = 6'h04;
    localparam logic [5:0]  OP_BNE       = 6'h05;
    localparam logic [5:0]  OP_J         = 6'h02;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of {pc+4, instruction} between fetch and decode
//   clk, rst        clock, synchronous active-high reset
//   flush           drop all entries (redirect)
//   push, wrData    write wrData at tail
//   pop             retire head entry
//   headData        head entry, all zeros when empty
//   count, full, empty  occupancy
module fetch_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] headData,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    headPtr;
    logic [PW-1:0]    tailPtr;

    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign headData = empty ? '0 : mem[headPtr];

    always_ff @(posedge clk) begin
        if (push && !flush) mem[tailPtr] <= wrData;
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (push) tailPtr <= tailPtr + 1'b1;
            if (pop) headPtr <= headPtr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction fetch into a small queue, redirect handling
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr / imem_data    InstructionMemory address (= pc) and same-cycle word
//   redirect / redirect_pc   taken branch or jump and its target (low two bits ignored)
//   id_ready / id_valid      decode handshake on the queue head
//   id_instr / id_pc_plus4   head instruction and its pc+4 (zero when empty)
//   stall_cnt                saturating count of cycles blocked by a full queue
module fetch_stage import mips_pkg::*; #(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [PC_W-1:0] id_pc_plus4,
    output logic [15:0]     stall_cnt
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PC_W-1:0] ALIGN = ~PC_W'(3);

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pcPlus4;
    logic [PC_W+31:0]   head;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign pcPlus4     = pc + PC_W'(PC_STEP);
    assign imem_addr   = pc;
    assign id_valid    = !empty;
    assign pop         = id_valid && id_ready;
    // a full queue still accepts a word when the head leaves this cycle
    assign push        = !redirect && (count < CW'(DEPTH) || pop);
    assign id_instr    = id_valid ? head[31:0] : NOP_INSTR;
    assign id_pc_plus4 = head[PC_W+31:32];

    fetch_fifo #(.WIDTH(PC_W + 32), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push     (push),
        .pop      (pop),
        .wrData   ({pcPlus4, imem_data}),
        .headData (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) pc <= RESET_PC & ALIGN;
        else if (redirect) pc <= redirect_pc & ALIGN;
        else if (push) pc <= pcPlus4;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= '0;
        else if (!redirect && !push && full && !pop && stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, corner sequences and a queue-model random run
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic        id_ready = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [7:0]  id_pc_plus4;
    logic [15:0] stall_cnt;
    int          nChecks = 0;
    int          nFails = 0;

    typedef struct {
        logic        rst, rdy, redir;
        logic [7:0]  rpc;
        logic        v;
        logic [31:0] instr;
        logic [7:0]  p4, addr;
        logic [15:0] stall;
    } vec_t;

    typedef struct {
        logic [7:0]  p4;
        logic [31:0] instr;
    } ent_t;

    vec_t vecs[15];
    ent_t q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [7:0] a);
        return (a == 8'h00) ? 32'h20080005 : {16'hC0DE, 8'h00, a};
    endfunction

    assign imem_data = word(imem_addr);

    fetch_stage #(.PC_W(8), .DEPTH(2), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc_plus4 (id_pc_plus4),
        .stall_cnt   (stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic v, input logic [31:0] instr,
                          input logic [7:0] p4, input logic [7:0] addr, input logic [15:0] stall);
        chk({tag, " id_valid"}, 32'(id_valid), 32'(v));
        chk({tag, " id_instr"}, id_instr, instr);
        chk({tag, " id_pc_plus4"}, 32'(id_pc_plus4), 32'(p4));
        chk({tag, " imem_addr"}, 32'(imem_addr), 32'(addr));
        chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(stall));
    endtask

    initial begin
        logic       rdy, redir, pop, push;
        logic [7:0] rpc, pcM;
        logic [15:0] stallM;
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0,          8'h00, 8'h00, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 32'h20080005,   8'h04, 8'h04, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 32'hC0DE0004,   8'h08, 8'h08, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 32'hC0DE0008,   8'h0C, 8'h0C, 16'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,          8'h00, 8'h00, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h20080005,   8'h04, 8'h04, 16'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h20080005,   8'h04, 8'h08, 16'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h20080005,   8'h04, 8'h08, 16'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h20080005,   8'h04, 8'h08, 16'd2};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 32'hC0DE0004,   8'h08, 8'h0C, 16'd2};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'hC0DE0004,   8'h08, 8'h0C, 16'd3};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h43, 1'b0, 32'h0,          8'h00, 8'h40, 16'd3};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'hC0DE0040,   8'h44, 8'h44, 16'd3};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 32'h0,          8'h00, 8'h10, 16'd3};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 32'hC0DE0010,   8'h14, 8'h14, 16'd3};

        for (int i = 0; i < 15; i++) begin
            rst         = vecs[i].rst;
            id_ready    = vecs[i].rdy;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            tick();
            chkAll($sformatf("row%0d", i), vecs[i].v, vecs[i].instr, vecs[i].p4, vecs[i].addr, vecs[i].stall);
        end

        // wrap of the PC past 0xFC
        redirect = 1'b1; redirect_pc = 8'hF8; id_ready = 1'b1;
        tick();
        chkAll("wrap redirect", 1'b0, 32'h0, 8'h00, 8'hF8, 16'd3);
        redirect = 1'b0;
        tick();
        chkAll("wrap fetchF8", 1'b1, 32'hC0DE00F8, 8'hFC, 8'hFC, 16'd3);
        tick();
        chkAll("wrap fetchFC", 1'b1, 32'hC0DE00FC, 8'h00, 8'h00, 16'd3);

        // reset beats a pending redirect on a full, stalled queue
        id_ready = 1'b0;
        tick();
        tick();
        chkAll("prereset full", 1'b1, 32'hC0DE00FC, 8'h00, 8'h04, 16'd4);
        rst = 1'b1; redirect = 1'b1; redirect_pc = 8'h80;
        tick();
        chkAll("midreset", 1'b0, 32'h0, 8'h00, 8'h00, 16'd0);
        rst = 1'b0; redirect = 1'b0;

        // random traffic against a queue model
        pcM = 8'h00;
        stallM = '0;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            chk("rnd id_valid", 32'(id_valid), 32'(q.size() != 0));
            chk("rnd id_instr", id_instr, q.size() != 0 ? q[0].instr : 32'h0);
            chk("rnd id_pc_plus4", 32'(id_pc_plus4), q.size() != 0 ? 32'(q[0].p4) : 32'h0);
            chk("rnd imem_addr", 32'(imem_addr), 32'(pcM));
            chk("rnd stall_cnt", 32'(stall_cnt), 32'(stallM));
            rdy   = $urandom_range(0, 9) < 5;
            redir = $urandom_range(0, 15) == 0;
            rpc   = 8'($urandom);
            id_ready = rdy; redirect = redir; redirect_pc = rpc;
            pop = q.size() > 0 && rdy;
            if (redir) begin
                q.delete();
                pcM = rpc & 8'hFC;
            end else begin
                push = q.size() < 2 || pop;
                if (pop) void'(q.pop_front());
                if (push) begin
                    q.push_back('{8'(pcM + 8'd4), word(pcM)});
                    pcM = pcM + 8'd4;
                end else if (q.size() == 2) stallM = stallM + 16'd1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
